// File: rtl/serial_frame_rx.sv
// Serial frame receiver: hunts for SYNC_WORD, deserializes FRAME_LEN words per frame and
// holds lock with a LOCK_MISS-deep flywheel. Optional per-word even parity via SFR_PARITY_EN.
module serial_frame_rx #(
    parameter int              DATA_W    = 8,
    parameter logic [DATA_W-1:0] SYNC_WORD = 8'hA5,
    parameter int              FRAME_LEN = 4,
    parameter int              LOCK_MISS = 2
) (
    input  logic              I_clk,
    input  logic              I_rst_n,
    input  logic              I_data_in,
    input  logic              I_data_vld,
    output logic [DATA_W-1:0] O_data,
    output logic              O_data_vld,
    output logic              O_sof,
    output logic              O_eof,
    output logic              O_locked,
`ifdef SFR_PARITY_EN
    output logic              O_par_err,
`endif
    output logic              O_sync_err
);

`ifdef SFR_PARITY_EN
    localparam int PAY_BITS = DATA_W + 1;
    localparam int SR_W     = DATA_W;     // full word kept while the parity bit arrives
`else
    localparam int PAY_BITS = DATA_W;
    localparam int SR_W     = DATA_W - 1;
`endif
    localparam int CW = $clog2(DATA_W + 2);
    localparam int WW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int MW = $clog2(LOCK_MISS + 1);

    typedef enum logic [1:0] {HUNT, PAYLOAD, CHECK} state_t;

    state_t            state_reg, state_next;
    logic [SR_W-1:0]   sr_reg, sr_next;
    logic [CW-1:0]     fill_cnt_reg, fill_cnt_next;
    logic [CW-1:0]     bit_cnt_reg, bit_cnt_next;
    logic [WW-1:0]     word_cnt_reg, word_cnt_next;
    logic [MW-1:0]     miss_cnt_reg, miss_cnt_next;
    logic [DATA_W-1:0] data_reg, data_next;
    logic              data_vld_reg, data_vld_next;
    logic              sof_reg, sof_next;
    logic              eof_reg, eof_next;
    logic              locked_reg, locked_next;
    logic              sync_err_reg, sync_err_next;
    logic              par_err_reg, par_err_next;
    logic [DATA_W-1:0] sample_word;
    logic [MW-1:0]     miss_inc;

    assign sample_word = {sr_reg[DATA_W-2:0], I_data_in};
    assign miss_inc    = miss_cnt_reg + MW'(1);

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_reg    <= HUNT;
            sr_reg       <= '0;
            fill_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            word_cnt_reg <= '0;
            miss_cnt_reg <= '0;
            data_reg     <= '0;
            data_vld_reg <= 1'b0;
            sof_reg      <= 1'b0;
            eof_reg      <= 1'b0;
            locked_reg   <= 1'b0;
            sync_err_reg <= 1'b0;
            par_err_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            sr_reg       <= sr_next;
            fill_cnt_reg <= fill_cnt_next;
            bit_cnt_reg  <= bit_cnt_next;
            word_cnt_reg <= word_cnt_next;
            miss_cnt_reg <= miss_cnt_next;
            data_reg     <= data_next;
            data_vld_reg <= data_vld_next;
            sof_reg      <= sof_next;
            eof_reg      <= eof_next;
            locked_reg   <= locked_next;
            sync_err_reg <= sync_err_next;
            par_err_reg  <= par_err_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        sr_next       = sr_reg;
        fill_cnt_next = fill_cnt_reg;
        bit_cnt_next  = bit_cnt_reg;
        word_cnt_next = word_cnt_reg;
        miss_cnt_next = miss_cnt_reg;
        data_next     = data_reg;
        data_vld_next = 1'b0;
        sof_next      = 1'b0;
        eof_next      = 1'b0;
        locked_next   = locked_reg;
        sync_err_next = 1'b0;
        par_err_next  = 1'b0;
        // Everything advances only on sampled bits; otherwise state fully holds.
        if (I_data_vld) begin
            sr_next = sample_word[SR_W-1:0];
            case (state_reg)
                HUNT: begin
                    if (fill_cnt_reg >= CW'(DATA_W - 1) && sample_word == SYNC_WORD) begin
                        state_next    = PAYLOAD;
                        locked_next   = 1'b1;
                        bit_cnt_next  = '0;
                        word_cnt_next = '0;
                        miss_cnt_next = '0;
                    end else if (fill_cnt_reg < CW'(DATA_W)) begin
                        fill_cnt_next = fill_cnt_reg + CW'(1);
                    end
                end
                PAYLOAD: begin
                    if (bit_cnt_reg == CW'(PAY_BITS - 1)) begin
                        bit_cnt_next  = '0;
                        data_vld_next = 1'b1;
`ifdef SFR_PARITY_EN
                        data_next     = sr_reg;
                        par_err_next  = (^sr_reg) ^ I_data_in;
`else
                        data_next     = sample_word;
`endif
                        sof_next      = (word_cnt_reg == '0);
                        eof_next      = (word_cnt_reg == WW'(FRAME_LEN - 1));
                        if (word_cnt_reg == WW'(FRAME_LEN - 1)) begin
                            word_cnt_next = '0;
                            state_next    = CHECK;
                        end else begin
                            word_cnt_next = word_cnt_reg + WW'(1);
                        end
                    end else begin
                        bit_cnt_next = bit_cnt_reg + CW'(1);
                    end
                end
                CHECK: begin
                    if (bit_cnt_reg == CW'(DATA_W - 1)) begin
                        bit_cnt_next = '0;
                        if (sample_word == SYNC_WORD) begin
                            miss_cnt_next = '0;
                            state_next    = PAYLOAD;
                        end else begin
                            sync_err_next = 1'b1;
                            if (miss_inc == MW'(LOCK_MISS)) begin
                                state_next    = HUNT;
                                locked_next   = 1'b0;
                                fill_cnt_next = '0;
                                miss_cnt_next = '0;
                            end else begin
                                miss_cnt_next = miss_inc;
                                state_next    = PAYLOAD;
                            end
                        end
                    end else begin
                        bit_cnt_next = bit_cnt_reg + CW'(1);
                    end
                end
                default: state_next = HUNT;
            endcase
        end
    end

    assign O_data     = data_reg;
    assign O_data_vld = data_vld_reg;
    assign O_sof      = sof_reg;
    assign O_eof      = eof_reg;
    assign O_locked   = locked_reg;
    assign O_sync_err = sync_err_reg;
`ifdef SFR_PARITY_EN
    assign O_par_err  = par_err_reg;
`else
    logic unused_par;
    assign unused_par = par_err_reg;
`endif

endmodule
